fetch_queue_unit: RTL and testbench

Parametrised instruction-fetch stage with a registered PC, a prioritised redirect network, a valid/ready instruction-cache request/response handshake and a FQ_DEPTH-entry fetch queue feeding decode. Sits between the branch-prediction/execute redirect sources and the IF/ID boundary. It replaces the purely combinational next-PC logic with a stall-tolerant, one-outstanding-request fetch engine.

---
 rtl/fetch_queue_unit_pkg.sv | 44 ++++
 rtl/fetch_queue_unit_if.sv | 42 ++++
 rtl/fetch_queue_unit_fetch_queue.sv | 68 ++++++
 rtl/fetch_queue_unit.sv | 192 +++++++++++++++++++
 tb/tb_fetch_queue_unit.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_queue_unit_pkg.sv
// ---------------------------------------------------------------------------
// fetch_queue_unit_pkg
// Shared types and defaults for the instruction-fetch stage:
//   - default address / instruction widths and reset PC
//   - fq_entry_t      : one fetch-queue entry {instr, pc, pred_taken}
//   - redirect_src_e  : which source steers the PC this cycle
//   - redirect_select : fixed-priority redirect arbitration
// No ports (package).
// ---------------------------------------------------------------------------
package fetch_queue_unit_pkg;

    localparam int          FQ_ADDR_W   = 12;
    localparam int          FQ_XLEN     = 32;
    localparam int unsigned FQ_RESET_PC = 0;

    typedef struct packed {
        logic [FQ_XLEN-1:0]   instr;
        logic [FQ_ADDR_W-1:0] pc;
        logic                 pred_taken;
    } fq_entry_t;

    typedef enum logic [2:0] {
        REDIR_NONE,
        REDIR_MISP_TAKEN,
        REDIR_MISP_NOT_TAKEN,
        REDIR_JALR,
        REDIR_JAL
    } redirect_src_e;

    // Resolved branches in EX/MEM are older than jumps in ID/EX, so they win.
    function automatic redirect_src_e redirect_select(
        input logic mispredict,
        input logic actual_taken,
        input logic jalr,
        input logic jal
    );
        if (mispredict && actual_taken)       return REDIR_MISP_TAKEN;
        else if (mispredict)                  return REDIR_MISP_NOT_TAKEN;
        else if (jalr)                        return REDIR_JALR;
        else if (jal)                         return REDIR_JAL;
        else                                  return REDIR_NONE;
    endfunction

endpackage

// File: rtl/fetch_queue_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_queue_unit_if
// Bundles the instruction-cache request/response handshake and the
// decode-side queue output of the fetch stage.
//   icache_req_valid/ready, icache_addr   : request channel (fetch -> cache)
//   icache_resp_valid, icache_resp_data   : response channel (cache -> fetch)
//   out_valid/ready, out_instr, out_pc,
//   out_pc_plus_4, out_pred_taken         : queue head to decode
// Modports: master = fetch stage, slave = cache/decode environment.
// ---------------------------------------------------------------------------
interface fetch_queue_unit_if
    import fetch_queue_unit_pkg::*;
#(
    parameter int ADDR_W = FQ_ADDR_W,
    parameter int XLEN   = FQ_XLEN
);
    logic              icache_req_valid;
    logic              icache_req_ready;
    logic [ADDR_W-1:0] icache_addr;
    logic              icache_resp_valid;
    logic [XLEN-1:0]   icache_resp_data;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_instr;
    logic [ADDR_W-1:0] out_pc;
    logic [ADDR_W-1:0] out_pc_plus_4;
    logic              out_pred_taken;

    modport master (
        output icache_req_valid, icache_addr,
        input  icache_req_ready, icache_resp_valid, icache_resp_data,
        output out_valid, out_instr, out_pc, out_pc_plus_4, out_pred_taken,
        input  out_ready
    );

    modport slave (
        input  icache_req_valid, icache_addr,
        output icache_req_ready, icache_resp_valid, icache_resp_data,
        input  out_valid, out_instr, out_pc, out_pc_plus_4, out_pred_taken,
        output out_ready
    );
endinterface

// File: rtl/fetch_queue_unit_fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// Circular-buffer FIFO of DEPTH entries (DEPTH a power of two).
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   i_clear         : drop all entries (wins over push/pop)
//   i_push, i_push_data : write an entry (accepted when not full or popping)
//   i_pop           : remove head (ignored when empty)
//   o_head          : head entry (registered storage, no bypass)
//   o_full, o_empty, o_count : occupancy status
// ---------------------------------------------------------------------------
module fetch_queue
    import fetch_queue_unit_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fq_entry_t,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = PTR_W + 1
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_push,
    input  entry_t           i_push_data,
    input  logic             i_pop,
    output entry_t           o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    entry_t           r_mem [DEPTH];

    logic w_do_pop;
    logic w_do_push;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rptr];

    // A push into a full queue is legal when the head leaves in the same cycle.
    assign w_do_pop  = i_pop && !o_empty && !i_clear;
    assign w_do_push = i_push && (!o_full || w_do_pop) && !i_clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_push_data;
    end

endmodule

// File: rtl/fetch_queue_unit.sv
// ---------------------------------------------------------------------------
// fetch_queue_unit
// Instruction-fetch stage: registered PC, prioritised redirect network,
// one-outstanding-request icache handshake and an FQ_DEPTH-entry fetch queue
// feeding decode.
// Ports:
//   clk, rst_n                     : clock, asynchronous active-low reset
//   i_mispredict, i_actual_taken,
//   i_ex_mem_branch_target, i_ex_mem_pc : resolved-branch redirect
//   i_id_ex_jalr, i_id_ex_jal,
//   i_jalr_target, i_jal_target    : unconditional-jump redirect
//   o_fetch_pc                     : current PC (also BTB lookup address)
//   i_btb_hit, i_predict_taken,
//   i_predict_target               : same-cycle BTB result for o_fetch_pc
//   bus (fetch_queue_unit_if.master) : icache request/response, decode output
// Optional feature (macro FETCH_PERF_CNT_EN):
//   o_perf_fetched : instructions pushed into the queue (wraps at 2^32)
//   o_perf_stall   : cycles with icache_req_valid && !icache_req_ready
// ---------------------------------------------------------------------------
module fetch_queue_unit
    import fetch_queue_unit_pkg::*;
#(
    parameter int          ADDR_W   = FQ_ADDR_W,
    parameter int          XLEN     = FQ_XLEN,
    parameter int          FQ_DEPTH = 4,
    parameter int unsigned RESET_PC = FQ_RESET_PC
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_mispredict,
    input  logic              i_actual_taken,
    input  logic [ADDR_W-1:0] i_ex_mem_branch_target,
    input  logic [ADDR_W-1:0] i_ex_mem_pc,
    input  logic              i_id_ex_jalr,
    input  logic              i_id_ex_jal,
    input  logic [ADDR_W-1:0] i_jalr_target,
    input  logic [ADDR_W-1:0] i_jal_target,
    output logic [ADDR_W-1:0] o_fetch_pc,
    input  logic              i_btb_hit,
    input  logic              i_predict_taken,
    input  logic [ADDR_W-1:0] i_predict_target,
    fetch_queue_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       o_perf_fetched,
    output logic [31:0]       o_perf_stall
`endif
);
    localparam int                CNT_W       = $clog2(FQ_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] PC_STEP     = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] LP_RESET_PC = ADDR_W'(RESET_PC);

    typedef struct packed {
        logic [XLEN-1:0]   instr;
        logic [ADDR_W-1:0] pc;
        logic              pred_taken;
    } entry_t;

    logic [ADDR_W-1:0] r_pc;
    logic              r_outstanding;
    logic              r_discard;
    logic [ADDR_W-1:0] r_req_pc;
    logic              r_req_pred;

    redirect_src_e     w_redir_src;
    logic              w_redirect;
    logic [ADDR_W-1:0] w_redir_target;
    logic              w_resp;
    logic              w_push;
    logic              w_pop;
    logic              w_room;
    logic              w_req_valid;
    logic              w_hs;
    logic              w_pred;
    logic              w_full;
    logic              w_empty;
    logic [CNT_W-1:0]  w_count;
    entry_t            w_push_data;
    entry_t            w_head;

    always_comb begin
        w_redir_src    = redirect_select(i_mispredict, i_actual_taken,
                                         i_id_ex_jalr, i_id_ex_jal);
        w_redir_target = '0;
        case (w_redir_src)
            REDIR_MISP_TAKEN:     w_redir_target = i_ex_mem_branch_target;
            REDIR_MISP_NOT_TAKEN: w_redir_target = i_ex_mem_pc + PC_STEP;
            REDIR_JALR:           w_redir_target = {i_jalr_target[ADDR_W-1:1], 1'b0};
            REDIR_JAL:            w_redir_target = i_jal_target;
            default:              w_redir_target = '0;
        endcase
    end

    assign w_redirect = (w_redir_src != REDIR_NONE);
    assign w_pred     = i_btb_hit && i_predict_taken;

    // A response only counts while a request is outstanding; a redirect in the
    // same cycle or a pending discard throws it away.
    assign w_resp = r_outstanding && bus.icache_resp_valid;
    assign w_push = w_resp && !r_discard && !w_redirect;
    assign w_pop  = !w_empty && bus.out_ready;

    // Issue only if the queue, after this cycle's push/pop, still has a free
    // slot for the response the new request will bring back.
    always_comb begin
        w_room = 1'b0;
        if (w_pop)       w_room = !w_push || !w_full;
        else if (w_push) w_room = (w_count < CNT_W'(FQ_DEPTH - 1));
        else             w_room = !w_full;
    end

    // The returning response frees the single request slot in its own cycle,
    // which is what allows one fetch per cycle with a one-cycle cache.
    assign w_req_valid = rst_n && !w_redirect && (!r_outstanding || w_resp) && w_room;
    assign w_hs        = w_req_valid && bus.icache_req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= LP_RESET_PC;
            r_outstanding <= 1'b0;
            r_discard     <= 1'b0;
        end else begin
            if (w_redirect)
                r_pc <= w_redir_target;
            else if (w_hs)
                r_pc <= w_pred ? i_predict_target : r_pc + PC_STEP;

            if (w_hs)        r_outstanding <= 1'b1;
            else if (w_resp) r_outstanding <= 1'b0;

            // A redirect that coincides with the response drops it directly,
            // so the flag is only needed when the response is still to come.
            if (w_resp)                          r_discard <= 1'b0;
            else if (w_redirect && r_outstanding) r_discard <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_hs) begin
            r_req_pc   <= r_pc;
            r_req_pred <= w_pred;
        end
    end

    assign w_push_data.instr      = bus.icache_resp_data;
    assign w_push_data.pc         = r_req_pc;
    assign w_push_data.pred_taken = r_req_pred;

    fetch_queue #(
        .DEPTH   (FQ_DEPTH),
        .entry_t (entry_t)
    ) u_fetch_queue (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clear     (w_redirect),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count)
    );

    assign o_fetch_pc         = r_pc;
    assign bus.icache_req_valid = w_req_valid;
    assign bus.icache_addr    = r_pc;
    assign bus.out_valid      = !w_empty;
    assign bus.out_instr      = w_head.instr;
    assign bus.out_pc         = w_head.pc;
    assign bus.out_pc_plus_4  = w_head.pc + PC_STEP;
    assign bus.out_pred_taken = w_head.pred_taken;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_fetched <= '0;
            r_perf_stall   <= '0;
        end else begin
            r_perf_fetched <= r_perf_fetched + 32'(w_push);
            r_perf_stall   <= r_perf_stall + 32'(w_req_valid && !bus.icache_req_ready);
        end
    end

    assign o_perf_fetched = r_perf_fetched;
    assign o_perf_stall   = r_perf_stall;
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue_unit
// Directed bench for fetch_queue_unit. A small cache model inside the tick
// task answers every accepted request after resp_lat cycles with the word
// 0xC0DE0000 | address. Perf-counter checks compile in with FETCH_PERF_CNT_EN.
// ---------------------------------------------------------------------------
module tb_fetch_queue_unit;
    localparam int ADDR_W = 12;
    localparam int XLEN   = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              mispredict = 1'b0;
    logic              actual_taken = 1'b0;
    logic [ADDR_W-1:0] ex_mem_branch_target = '0;
    logic [ADDR_W-1:0] ex_mem_pc = '0;
    logic              id_ex_jalr = 1'b0;
    logic              id_ex_jal = 1'b0;
    logic [ADDR_W-1:0] jalr_target = '0;
    logic [ADDR_W-1:0] jal_target = '0;
    logic [ADDR_W-1:0] fetch_pc;
    logic              btb_hit = 1'b0;
    logic              predict_taken = 1'b0;
    logic [ADDR_W-1:0] predict_target = '0;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]       perf_fetched;
    logic [31:0]       perf_stall;
`endif

    int total = 0;
    int bad   = 0;

    int                resp_lat = 1;
    logic              pend = 1'b0;
    int                pcnt = 0;
    logic [ADDR_W-1:0] paddr = '0;

    fetch_queue_unit_if #(.ADDR_W(ADDR_W), .XLEN(XLEN)) bus ();

    fetch_queue_unit #(
        .ADDR_W   (ADDR_W),
        .XLEN     (XLEN),
        .FQ_DEPTH (4),
        .RESET_PC (0)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .i_mispredict           (mispredict),
        .i_actual_taken         (actual_taken),
        .i_ex_mem_branch_target (ex_mem_branch_target),
        .i_ex_mem_pc            (ex_mem_pc),
        .i_id_ex_jalr           (id_ex_jalr),
        .i_id_ex_jal            (id_ex_jal),
        .i_jalr_target          (jalr_target),
        .i_jal_target           (jal_target),
        .o_fetch_pc             (fetch_pc),
        .i_btb_hit              (btb_hit),
        .i_predict_taken        (predict_taken),
        .i_predict_target       (predict_target),
        .bus                    (bus)
`ifdef FETCH_PERF_CNT_EN
        ,
        .o_perf_fetched         (perf_fetched),
        .o_perf_stall           (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: capture the handshake before the edge, then update the
    // cache response for the new cycle just after it.
    task automatic tick();
        @(negedge clk);
        if (bus.icache_req_valid && bus.icache_req_ready) begin
            pend  = 1'b1;
            pcnt  = resp_lat;
            paddr = bus.icache_addr;
        end
        @(posedge clk);
        #1;
        bus.icache_resp_valid = 1'b0;
        if (pend) begin
            pcnt--;
            if (pcnt == 0) begin
                bus.icache_resp_valid = 1'b1;
                bus.icache_resp_data  = 32'hC0DE_0000 | 32'(paddr);
                pend = 1'b0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pend  = 1'b0;
        bus.icache_resp_valid = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_req_valid", 32'(bus.icache_req_valid), 32'd0);
        chk("rst_fetch_pc", 32'(fetch_pc), 32'h000);
`ifdef FETCH_PERF_CNT_EN
        chk("rst_perf_fetched", perf_fetched, 32'd0);
        chk("rst_perf_stall", perf_stall, 32'd0);
`endif
        rst_n = 1'b1;
        #1;
        chk("post_rst_req_valid", 32'(bus.icache_req_valid), 32'd1);
    endtask

    initial begin
        bus.icache_req_ready  = 1'b1;
        bus.icache_resp_valid = 1'b0;
        bus.icache_resp_data  = '0;
        bus.out_ready         = 1'b1;

        // Streaming at one instruction per cycle
        do_reset();
        tick();
        chk("t1_c1_empty", 32'(bus.out_valid), 32'd0);
        tick();
        chk("t1_c2_valid", 32'(bus.out_valid), 32'd1);
        chk("t1_c2_pc", 32'(bus.out_pc), 32'h000);
        chk("t1_c2_instr", bus.out_instr, 32'hC0DE_0000);
        tick();
        chk("t1_c3_pc", 32'(bus.out_pc), 32'h004);
        tick();
        chk("t1_c4_pc", 32'(bus.out_pc), 32'h008);
        chk("t1_c4_pc4", 32'(bus.out_pc_plus_4), 32'h00C);
`ifdef FETCH_PERF_CNT_EN
        chk("t1_perf_fetched", perf_fetched, 32'd3);
`endif

        // Decode stalls: queue fills to exactly four entries, then drains
        bus.out_ready = 1'b0;
        repeat (10) tick();
        chk("t2_full_valid", 32'(bus.out_valid), 32'd1);
        chk("t2_full_head", 32'(bus.out_pc), 32'h008);
        chk("t2_full_noreq", 32'(bus.icache_req_valid), 32'd0);
        chk("t2_full_pc", 32'(fetch_pc), 32'h018);
        bus.out_ready = 1'b1;
        #1;
        chk("t2_pop_req", 32'(bus.icache_req_valid), 32'd1);
        tick();
        chk("t2_d1_pc", 32'(bus.out_pc), 32'h00C);
        tick();
        chk("t2_d2_pc", 32'(bus.out_pc), 32'h010);
        tick();
        chk("t2_d3_pc", 32'(bus.out_pc), 32'h014);
        tick();
        chk("t2_d4_pc", 32'(bus.out_pc), 32'h018);

        // Taken mispredict while a two-cycle response is in flight
        resp_lat = 2;
        do_reset();
        tick();
        chk("t3_outstanding_noreq", 32'(bus.icache_req_valid), 32'd0);
        mispredict = 1'b1;
        actual_taken = 1'b1;
        ex_mem_branch_target = 12'h200;
        tick();
        mispredict = 1'b0;
        actual_taken = 1'b0;
        #1;
        chk("t3_fetch_pc", 32'(fetch_pc), 32'h200);
        chk("t3_flush_valid", 32'(bus.out_valid), 32'd0);
        chk("t3_req_after_stale", 32'(bus.icache_req_valid), 32'd1);
        tick();
        chk("t3_stale_dropped", 32'(bus.out_valid), 32'd0);
        tick();
        chk("t3_still_empty", 32'(bus.out_valid), 32'd0);
        tick();
        chk("t3_new_valid", 32'(bus.out_valid), 32'd1);
        chk("t3_new_pc", 32'(bus.out_pc), 32'h200);
        chk("t3_new_instr", bus.out_instr, 32'hC0DE_0200);

        // Not-taken mispredict beats a jal; redirect coincides with response
        resp_lat = 1;
        do_reset();
        tick();
        mispredict = 1'b1;
        actual_taken = 1'b0;
        ex_mem_pc = 12'h040;
        id_ex_jal = 1'b1;
        jal_target = 12'h300;
        #1;
        chk("t4_redir_drops_req", 32'(bus.icache_req_valid), 32'd0);
        tick();
        mispredict = 1'b0;
        id_ex_jal = 1'b0;
        #1;
        chk("t4_fetch_pc", 32'(fetch_pc), 32'h044);
        chk("t4_flush_valid", 32'(bus.out_valid), 32'd0);
        chk("t4_req_valid", 32'(bus.icache_req_valid), 32'd1);
        tick();
        chk("t4_resp_dropped", 32'(bus.out_valid), 32'd0);
        tick();
        chk("t4_out_pc", 32'(bus.out_pc), 32'h044);
        chk("t4_out_pred", 32'(bus.out_pred_taken), 32'd0);
        id_ex_jalr = 1'b1;
        jalr_target = 12'h123;
        id_ex_jal = 1'b1;
        jal_target = 12'h300;
        tick();
        id_ex_jalr = 1'b0;
        id_ex_jal = 1'b0;
        #1;
        chk("t4_jalr_pc", 32'(fetch_pc), 32'h122);
        chk("t4_jalr_flush", 32'(bus.out_valid), 32'd0);
        id_ex_jal = 1'b1;
        jal_target = 12'h300;
        tick();
        id_ex_jal = 1'b0;
        #1;
        chk("t4_jal_pc", 32'(fetch_pc), 32'h300);

        // BTB taken prediction at 0x010 steering to 0x080
        do_reset();
        id_ex_jal = 1'b1;
        jal_target = 12'h010;
        tick();
        id_ex_jal = 1'b0;
        btb_hit = 1'b1;
        predict_taken = 1'b1;
        predict_target = 12'h080;
        #1;
        chk("t5_req_at_010", 32'(bus.icache_req_valid), 32'd1);
        chk("t5_addr_010", 32'(bus.icache_addr), 32'h010);
        tick();
        btb_hit = 1'b0;
        predict_taken = 1'b0;
        #1;
        chk("t5_fetch_pc", 32'(fetch_pc), 32'h080);
        tick();
        chk("t5_out0_pc", 32'(bus.out_pc), 32'h010);
        chk("t5_out0_pred", 32'(bus.out_pred_taken), 32'd1);
        tick();
        chk("t5_out1_pc", 32'(bus.out_pc), 32'h080);
        chk("t5_out1_pred", 32'(bus.out_pred_taken), 32'd0);

        // Sequential wrap from 0xFFC
        do_reset();
        id_ex_jal = 1'b1;
        jal_target = 12'hFFC;
        tick();
        id_ex_jal = 1'b0;
        tick();
        chk("t6_wrap_fetch_pc", 32'(fetch_pc), 32'h000);
        tick();
        chk("t6_out_ffc", 32'(bus.out_pc), 32'hFFC);
        chk("t6_out_ffc_pc4", 32'(bus.out_pc_plus_4), 32'h000);
        tick();
        chk("t6_out_wrap", 32'(bus.out_pc), 32'h000);

        // Cache not ready for three cycles: request held, stalls counted
        do_reset();
        bus.icache_req_ready = 1'b0;
        #1;
        tick();
        chk("t7_hold_valid1", 32'(bus.icache_req_valid), 32'd1);
        chk("t7_hold_addr1", 32'(bus.icache_addr), 32'h000);
        tick();
        tick();
        chk("t7_hold_valid3", 32'(bus.icache_req_valid), 32'd1);
        chk("t7_hold_addr3", 32'(bus.icache_addr), 32'h000);
`ifdef FETCH_PERF_CNT_EN
        chk("t7_perf_stall", perf_stall, 32'd3);
`endif
        bus.icache_req_ready = 1'b1;
        tick();
        chk("t7_fetch_pc", 32'(fetch_pc), 32'h004);
        tick();
        chk("t7_out_pc", 32'(bus.out_pc), 32'h000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
